reg16_piso_reader: RTL
======================

REG16_PISO_READER -- requirements
Module: reg16_piso_reader

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = bit 15 is shifted out first, 0 = bit 0 first.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port d  input  16  parallel word from the 16-bit memory register output.
REQ-005 SHALL have port load  input  1  request to capture d and start serialisation.
REQ-006 SHALL have port en  input  1  shift enable; 0 stalls the shift (consumer not ready).
REQ-007 SHALL have port sout  output  1  current serial bit.
REQ-008 SHALL have port sout_valid  output  1  sout holds a valid data bit.
REQ-009 SHALL have port busy  output  1  a word is in progress (SHIFT or DONE).
REQ-010 SHALL have port done  output  1  one-cycle pulse after the last bit is accepted.

Function
REQ-011 SHALL implement a state machine with states IDLE, SHIFT and DONE, a 16-bit shift register and a 4-bit bit counter.
REQ-012 In IDLE, a rising edge with load=1 SHALL capture d into the shift register, clear the counter and enter SHIFT.
- This edge is E0.
REQ-013 In SHIFT, sout SHALL equal shreg[15] when MSB_FIRST=1 and shreg[0] when MSB_FIRST=0.
- sout_valid=1 and busy=1 throughout SHIFT.
REQ-014 In SHIFT, a rising edge with en=1 SHALL accept the current bit.
- Shift one position toward the output end, zero-filling.
- Increment the counter.
REQ-015 In SHIFT, a rising edge with en=0 SHALL leave the shift register, counter and sout unchanged.
- sout_valid stays 1.
REQ-016 An accepting edge with counter=15 SHALL move to DONE; the counter wraps to 0.
REQ-017 In DONE, done=1, busy=1, sout_valid=0 and sout=0; the next edge SHALL return to IDLE unconditionally.
REQ-018 In IDLE, sout=0, sout_valid=0, busy=0 and done=0.
REQ-019 load SHALL be ignored in SHIFT and DONE; d is sampled only at E0.
- Later changes to d do not affect the word in flight.
REQ-020 load=1 on the edge that returns DONE->IDLE SHALL be ignored.
- A new word starts no earlier than the first edge at which the block is already in IDLE.
REQ-021 With en held 1, latency SHALL be fixed:
- Bits are presented in the 16 cycles following E0..E15.
- DONE is entered at E16; done=1 in the cycle after E16.
- busy=0 after E17.
REQ-022 Every stalled cycle (en=0 in SHIFT) SHALL extend the REQ-021 timing by exactly one cycle.
REQ-023 en SHALL have no effect in IDLE or DONE.
REQ-024 All outputs SHALL be registered or decoded only from state and shift register, with no combinational path from inputs.

Reset
REQ-025 rst=1 SHALL immediately, without waiting for clk, force:
- state=IDLE, shift register=0, counter=0;
- sout=0, sout_valid=0, busy=0, done=0.
REQ-026 Reset during SHIFT or DONE SHALL abort the word with no done pulse.
- The first load edge after rst deasserts starts a fresh word.
REQ-027 While rst=1, load and en SHALL be ignored.

Verification
REQ-028 Bench SHALL cover: MSB_FIRST=1, d=16'h8001, load 1 cycle, en=1 -> sout 1,0×14,1 in cycles after E0..E15; done pulse after E16; busy=0 after E17.
REQ-029 Bench SHALL cover: MSB_FIRST=0, d=16'h00F3 -> sout sequence 1,1,0,0,1,1,1,1, then 0×8.
REQ-030 Bench SHALL cover: d=16'hA5A5, en=0 for 3 cycles after bit 4 -> bit 4 (value 0) held with sout_valid=1 for 4 cycles; done after E19.
REQ-031 Bench SHALL cover: load=1 held continuously, d changed to 16'h1234 mid-word -> first word 16'hA5A5 output intact; second word 16'h1234 starts at the first edge in IDLE after done.
REQ-032 Bench SHALL cover: rst pulsed asynchronously between edges after bit 7 -> all outputs 0 before the next clk edge; no done pulse; a new load of 16'hFFFF yields 16 ones.
REQ-033 Bench SHALL cover: load and en toggled during DONE -> no effect; exactly one done pulse per word.

Source files
------------

// File: rtl/reg16_piso_reader.sv
// 16-bit parallel-in serial-out reader for a memory register word.
// Captures d on load, shifts it out one bit per enabled cycle, then pulses done.
module reg16_piso_reader #(
  parameter int MSB_FIRST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  input  logic        load,
  input  logic        en,
  output logic        sout,
  output logic        sout_valid,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] shreg;
  logic [3:0]  cnt;
  logic [15:0] nxt;

  // Word after one accepted bit: move toward the output end, zero-fill.
  always_comb begin
    nxt = shreg;
    if (MSB_FIRST != 0)
      nxt = {shreg[14:0], 1'b0};
    else
      nxt = {1'b0, shreg[15:1]};
  end

  function automatic logic outbit(input logic [15:0] w);
    return (MSB_FIRST != 0) ? w[15] : w[0];
  endfunction

  // sout is registered from the word it will present next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= 16'h0000;
      cnt        <= 4'd0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load) begin
            state      <= SHIFT;
            shreg      <= d;
            cnt        <= 4'd0;
            sout       <= outbit(d);
            sout_valid <= 1'b1;
            busy       <= 1'b1;
          end
        end
        SHIFT: begin
          if (en) begin
            shreg <= nxt;
            cnt   <= cnt + 4'd1;
            if (cnt == 4'd15) begin
              state      <= DONE;
              sout       <= 1'b0;
              sout_valid <= 1'b0;
              done       <= 1'b1;
            end else begin
              sout <= outbit(nxt);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          shreg      <= 16'h0000;
          cnt        <= 4'd0;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
